// File: rtl/btb_update_ctrl.sv
// btb_update_ctrl: buffers resolved branch records in a DEPTH-entry FIFO and drains them as
// registered BTB writes; a flush runs a 32-entry invalidate sweep. Optional stats: BTB_UPD_STATS_EN.
module btb_update_ctrl #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rs_valid,
  input  logic [31:0] rs_pc,
  input  logic [31:0] rs_target,
  input  logic        rs_taken,
  output logic        rs_ready,
  input  logic        flush_req,
  output logic        flush_busy,
  output logic        wr_en,
  output logic [4:0]  wr_idx,
  output logic [24:0] wr_tag,
  output logic [31:0] wr_target,
  output logic        wr_taken,
  output logic        wr_clear
`ifdef BTB_UPD_STATS_EN
  ,
  output logic [31:0] stat_updates,
  output logic [15:0] stat_sweeps
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    SWEEP = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic          r_pending;
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_next;

  // PC bits [1:0] never take part in BTB indexing or tagging, so only [31:2] is stored.
  logic [29:0]   r_mem_pc     [DEPTH];
  logic [31:0]   r_mem_target [DEPTH];
  logic          r_mem_taken  [DEPTH];
  logic          w_unused_pc_lsb;

  logic [29:0]   w_head_pc;
  logic [31:0]   w_head_target;
  logic          w_head_taken;

  logic          w_push;
  logic          w_pop;
  logic          w_sweep_start;
  logic          w_sweep_last;

  logic          r_wr_en;
  logic          r_wr_clear;
  logic [4:0]    r_wr_idx;
  logic [24:0]   r_wr_tag;
  logic [31:0]   r_wr_target;
  logic          r_wr_taken;

  assign w_unused_pc_lsb = ^rs_pc[1:0];

  assign rs_ready      = (r_count < FULL_CNT);
  assign w_push        = rs_valid && rs_ready;
  // A pending flush wins over the next pop, so the sweep slots in between records.
  assign w_pop         = (r_state == DRAIN) && !r_pending && (r_count != '0);
  assign w_sweep_start = r_pending && (r_state != SWEEP);
  assign w_sweep_last  = (r_state == SWEEP) && (r_wr_idx == 5'd31);
  assign flush_busy    = r_pending || (r_state == SWEEP);

  assign w_head_pc     = r_mem_pc[r_rptr];
  assign w_head_target = r_mem_target[r_rptr];
  assign w_head_taken  = r_mem_taken[r_rptr];

  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + CW'(1);
      2'b01:   w_count_next = r_count - CW'(1);
      default: w_count_next = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_pc[r_wptr]     <= rs_pc[31:2];
      r_mem_target[r_wptr] <= rs_target;
      r_mem_taken[r_wptr]  <= rs_taken;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      r_count <= w_count_next;
    end
  end

  // Requests arriving during a sweep are absorbed by it; the flag clears as a sweep begins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pending <= 1'b0;
    end else if (w_sweep_start) begin
      r_pending <= 1'b0;
    end else if (flush_req && (r_state != SWEEP)) begin
      r_pending <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (r_pending) begin
          w_state_next = SWEEP;
        end else if (r_count != '0) begin
          w_state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (r_pending) begin
          w_state_next = SWEEP;
        end else if (w_count_next == '0) begin
          w_state_next = IDLE;
        end
      end
      SWEEP: begin
        if (w_sweep_last) begin
          w_state_next = (w_count_next != '0) ? DRAIN : IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // The sweep's first clear is issued on the entry edge; wr_idx then doubles as the sweep counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_en     <= 1'b0;
      r_wr_clear  <= 1'b0;
      r_wr_idx    <= 5'd0;
      r_wr_tag    <= 25'd0;
      r_wr_target <= 32'd0;
      r_wr_taken  <= 1'b0;
    end else if (w_sweep_start) begin
      r_wr_en     <= 1'b1;
      r_wr_clear  <= 1'b1;
      r_wr_idx    <= 5'd0;
      r_wr_tag    <= 25'd0;
      r_wr_target <= 32'd0;
      r_wr_taken  <= 1'b0;
    end else if ((r_state == SWEEP) && !w_sweep_last) begin
      r_wr_en     <= 1'b1;
      r_wr_clear  <= 1'b1;
      r_wr_idx    <= r_wr_idx + 5'd1;
    end else if (w_pop) begin
      r_wr_en     <= 1'b1;
      r_wr_clear  <= 1'b0;
      r_wr_idx    <= w_head_pc[4:0];
      r_wr_tag    <= w_head_pc[29:5];
      r_wr_target <= w_head_target;
      r_wr_taken  <= w_head_taken;
    end else begin
      r_wr_en     <= 1'b0;
    end
  end

  assign wr_en     = r_wr_en;
  assign wr_clear  = r_wr_clear;
  assign wr_idx    = r_wr_idx;
  assign wr_tag    = r_wr_tag;
  assign wr_target = r_wr_target;
  assign wr_taken  = r_wr_taken;

`ifdef BTB_UPD_STATS_EN
  logic [31:0] r_stat_updates;
  logic [15:0] r_stat_sweeps;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stat_updates <= 32'd0;
      r_stat_sweeps  <= 16'd0;
    end else begin
      if (w_pop) begin
        r_stat_updates <= r_stat_updates + 32'd1;
      end
      if (w_sweep_last) begin
        r_stat_sweeps <= r_stat_sweeps + 16'd1;
      end
    end
  end

  assign stat_updates = r_stat_updates;
  assign stat_sweeps  = r_stat_sweeps;
`endif

endmodule

// File: tb/tb_btb_update_ctrl.sv
// Bench for btb_update_ctrl: a directed vector table, hand-written multi-cycle sequences,
// then random traffic checked against a queue-based scoreboard.
module tb_btb_update_ctrl;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rs_valid = 1'b0;
  logic [31:0] rs_pc = 32'd0;
  logic [31:0] rs_target = 32'd0;
  logic        rs_taken = 1'b0;
  logic        flush_req = 1'b0;
  logic        rs_ready;
  logic        flush_busy;
  logic        wr_en;
  logic [4:0]  wr_idx;
  logic [24:0] wr_tag;
  logic [31:0] wr_target;
  logic        wr_taken;
  logic        wr_clear;
`ifdef BTB_UPD_STATS_EN
  logic [31:0] stat_updates;
  logic [15:0] stat_sweeps;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] tgt;
    logic        tk;
  } rec_t;

  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic [31:0] tgt;
    logic        tk;
    logic        e_en;
    logic [4:0]  e_idx;
    logic [24:0] e_tag;
    logic [31:0] e_tgt;
    logic        e_tk;
    logic        e_rdy;
  } vec_t;

  vec_t vecs[10];

  rec_t       q[$];
  logic [4:0] sweep_next;
  logic [4:0] last_idx;
  logic [24:0] last_tag;
  logic [31:0] last_tgt;
  logic       last_tk;

  always #5 clk = ~clk;

  btb_update_ctrl #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .rs_valid   (rs_valid),
    .rs_pc      (rs_pc),
    .rs_target  (rs_target),
    .rs_taken   (rs_taken),
    .rs_ready   (rs_ready),
    .flush_req  (flush_req),
    .flush_busy (flush_busy),
`ifdef BTB_UPD_STATS_EN
    .stat_updates (stat_updates),
    .stat_sweeps  (stat_sweeps),
`endif
    .wr_en      (wr_en),
    .wr_idx     (wr_idx),
    .wr_tag     (wr_tag),
    .wr_target  (wr_target),
    .wr_taken   (wr_taken),
    .wr_clear   (wr_clear)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_rec(input string name, input logic [31:0] pc, input logic [31:0] tgt,
                         input logic tk);
    chk({name, "_en"},     wr_en,     1);
    chk({name, "_clr"},    wr_clear,  0);
    chk({name, "_idx"},    wr_idx,    pc[6:2]);
    chk({name, "_tag"},    wr_tag,    pc[31:7]);
    chk({name, "_target"}, wr_target, tgt);
    chk({name, "_taken"},  wr_taken,  tk);
    $display("%s: write idx=%0d tag=0x%0h target=0x%0h taken=%0b", name, wr_idx, wr_tag,
             wr_target, wr_taken);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rs_valid  = 1'b0;
    rs_pc     = 32'd0;
    rs_target = 32'd0;
    rs_taken  = 1'b0;
    flush_req = 1'b0;
    reset     = 1'b0;
    step();
    step();
    reset     = 1'b1;
  endtask

  task automatic wait_wr(input int max_cyc, output bit got);
    got = 1'b0;
    for (int i = 0; i < max_cyc && !got; i++) begin
      step();
      if (wr_en) got = 1'b1;
    end
  endtask

  function automatic rec_t ovf_rec(input int i);
    rec_t r;
    r.pc  = 32'h0000_2000 + 32'(i) * 32'h104;
    r.tgt = 32'h3000_0000 + 32'(i);
    r.tk  = i[0];
    return r;
  endfunction

  function automatic rec_t ss_rec(input int k);
    rec_t r;
    r.pc  = 32'h1000_0000 + 32'(k) * 32'h84;
    r.tgt = 32'hA000_0000 + 32'(k);
    r.tk  = k[0];
    return r;
  endfunction

  // Scoreboard step: accepted pushes join the queue, drain writes must match its head,
  // clear writes must walk 0..31, and idle cycles must hold the last written values.
  task automatic rand_observe(input bit accepted, input rec_t rec);
    rec_t exp;
    if (accepted) q.push_back(rec);
    if (wr_en) begin
      if (wr_clear) begin
        chk("rnd_sweep_idx", wr_idx, sweep_next);
        chk("rnd_sweep_data", {wr_tag, wr_target, wr_taken}, 0);
        chk("rnd_sweep_busy", flush_busy, 1);
        last_idx   = sweep_next;
        last_tag   = 25'd0;
        last_tgt   = 32'd0;
        last_tk    = 1'b0;
        sweep_next = sweep_next + 5'd1;
      end else begin
        chk("rnd_drain_mid_sweep", sweep_next, 0);
        chk("rnd_queue_nonempty", q.size() != 0, 1);
        if (q.size() != 0) begin
          exp = q.pop_front();
          chk_rec("rnd_drain", exp.pc, exp.tgt, exp.tk);
          last_idx = exp.pc[6:2];
          last_tag = exp.pc[31:7];
          last_tgt = exp.tgt;
          last_tk  = exp.tk;
        end
      end
    end else begin
      chk("rnd_hold", {wr_idx, wr_tag, wr_target, wr_taken},
          {last_idx, last_tag, last_tgt, last_tk});
    end
    chk("rnd_rs_ready", rs_ready, q.size() < DEPTH);
  endtask

  initial begin
    bit   got;
    int   n;
    rec_t r;
    bit   acc;

    vecs[0] = '{1'b1, 32'h0000_0084, 32'h0000_0100, 1'b1, 1'b0, 5'd0,  25'h0,       32'h0,         1'b0, 1'b1};
    vecs[1] = '{1'b0, 32'h0,         32'h0,         1'b0, 1'b0, 5'd0,  25'h0,       32'h0,         1'b0, 1'b1};
    vecs[2] = '{1'b0, 32'h0,         32'h0,         1'b0, 1'b1, 5'd1,  25'h1,       32'h100,       1'b1, 1'b1};
    vecs[3] = '{1'b0, 32'h0,         32'h0,         1'b0, 1'b0, 5'd1,  25'h1,       32'h100,       1'b1, 1'b1};
    vecs[4] = '{1'b1, 32'h0000_1008, 32'h0000_2000, 1'b0, 1'b0, 5'd1,  25'h1,       32'h100,       1'b1, 1'b1};
    vecs[5] = '{1'b1, 32'hFFFF_FFFC, 32'hDEAD_BEEC, 1'b1, 1'b0, 5'd1,  25'h1,       32'h100,       1'b1, 1'b1};
    vecs[6] = '{1'b1, 32'h1234_5678, 32'h0,         1'b0, 1'b1, 5'd2,  25'h20,      32'h2000,      1'b0, 1'b1};
    vecs[7] = '{1'b0, 32'h0,         32'h0,         1'b0, 1'b1, 5'd31, 25'h1FFFFFF, 32'hDEAD_BEEC, 1'b1, 1'b1};
    vecs[8] = '{1'b0, 32'h0,         32'h0,         1'b0, 1'b1, 5'd30, 25'h2468AC,  32'h0,         1'b0, 1'b1};
    vecs[9] = '{1'b0, 32'h0,         32'h0,         1'b0, 1'b0, 5'd30, 25'h2468AC,  32'h0,         1'b0, 1'b1};

    // Asynchronous reset takes effect without a clock edge.
    #2 reset = 1'b0;
    #1;
    chk("rst_async_wr_en", wr_en, 0);
    chk("rst_async_busy", flush_busy, 0);
    step();
    step();
    chk("rst_wr_fields", {wr_en, wr_clear, wr_idx, wr_tag, wr_target, wr_taken}, 0);
    chk("rst_rs_ready", rs_ready, 1);
    chk("rst_flush_busy", flush_busy, 0);
`ifdef BTB_UPD_STATS_EN
    chk("rst_stat_updates", stat_updates, 0);
    chk("rst_stat_sweeps", stat_sweeps, 0);
`endif
    reset = 1'b1;

    for (int i = 0; i < 10; i++) begin
      rs_valid  = vecs[i].v;
      rs_pc     = vecs[i].pc;
      rs_target = vecs[i].tgt;
      rs_taken  = vecs[i].tk;
      step();
      chk("vec_wr_en", wr_en, vecs[i].e_en);
      if (vecs[i].e_en) chk("vec_wr_clear", wr_clear, 0);
      chk("vec_wr_idx", wr_idx, vecs[i].e_idx);
      chk("vec_wr_tag", wr_tag, vecs[i].e_tag);
      chk("vec_wr_target", wr_target, vecs[i].e_tgt);
      chk("vec_wr_taken", wr_taken, vecs[i].e_tk);
      chk("vec_rs_ready", rs_ready, vecs[i].e_rdy);
      chk("vec_flush_busy", flush_busy, 0);
      $display("vec %0d: wr_en=%0b idx=%0d tag=0x%0h target=0x%0h taken=%0b ready=%0b", i, wr_en,
               wr_idx, wr_tag, wr_target, wr_taken, rs_ready);
    end
    rs_valid = 1'b0;

    // Flush with two records queued: 32 clears first, then both records in order.
    do_reset();
    rs_valid = 1'b1; rs_pc = 32'h0000_0600; rs_target = 32'h0000_7000; rs_taken = 1'b0;
    step();
    rs_pc = 32'h8000_0044; rs_target = 32'h8000_1000; rs_taken = 1'b1; flush_req = 1'b1;
    step();
    rs_valid = 1'b0; flush_req = 1'b0;
    chk("fl_busy_pending", flush_busy, 1);
    wait_wr(5, got);
    chk("fl_sweep_seen", got, 1);
    for (int k = 0; k < 32; k++) begin
      if (k > 0) step();
      chk("fl_sweep_en", wr_en, 1);
      chk("fl_sweep_clr", wr_clear, 1);
      chk("fl_sweep_idx", wr_idx, k[4:0]);
      chk("fl_sweep_busy", flush_busy, 1);
      chk("fl_sweep_data", {wr_tag, wr_target, wr_taken}, 0);
    end
    $display("flush: 32 clear writes observed");
    wait_wr(5, got);
    chk("fl_rec1_seen", got, 1);
    chk_rec("fl_rec1", 32'h0000_0600, 32'h0000_7000, 1'b0);
    step();
    chk_rec("fl_rec2", 32'h8000_0044, 32'h8000_1000, 1'b1);
    step();
    chk("fl_after_en", wr_en, 0);
    chk("fl_after_busy", flush_busy, 0);

    // Five pushes while a sweep stalls draining: fourth fills the FIFO, fifth is dropped.
    do_reset();
    flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    chk("ovf_pending_busy", flush_busy, 1);
    step();
    chk("ovf_sweep_start", {wr_en, wr_clear, wr_idx}, {1'b1, 1'b1, 5'd0});
    for (int i = 0; i < 5; i++) begin
      r = ovf_rec(i);
      rs_valid = 1'b1; rs_pc = r.pc; rs_target = r.tgt; rs_taken = r.tk;
      chk("ovf_ready_before_push", rs_ready, i < 4);
      step();
    end
    rs_valid = 1'b0;
    chk("ovf_ready_full", rs_ready, 0);
    chk("ovf_still_sweeping", flush_busy, 1);
    n = 0;
    for (int c = 0; c < 80; c++) begin
      step();
      if (wr_en && !wr_clear) begin
        if (n < 4) begin
          r = ovf_rec(n);
          chk_rec("ovf_rec", r.pc, r.tgt, r.tk);
        end
        n++;
      end
    end
    chk("ovf_drain_count", n, 4);
    chk("ovf_ready_after", rs_ready, 1);

    // Reset asserted mid-sweep with records queued: everything is discarded.
    do_reset();
    flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    rs_valid = 1'b1; rs_pc = 32'h0000_5004; rs_target = 32'h0000_0011; rs_taken = 1'b1;
    step();
    rs_pc = 32'h0000_5008;
    step();
    rs_valid = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      if (wr_en && wr_clear && (wr_idx == 5'd10)) got = 1'b1;
      else step();
    end
    chk("rst_reached_idx10", got, 1);
    #2 reset = 1'b0;
    #1;
    chk("rst_mid_wr_en", wr_en, 0);
    chk("rst_mid_wr_clear", wr_clear, 0);
    chk("rst_mid_wr_idx", wr_idx, 0);
    chk("rst_mid_busy", flush_busy, 0);
    chk("rst_mid_ready", rs_ready, 1);
    step();
    step();
    reset = 1'b1;
    n = 0;
    for (int c = 0; c < 50; c++) begin
      step();
      if (wr_en) n++;
    end
    chk("rst_no_writes_after", n, 0);
    chk("rst_busy_after", flush_busy, 0);
    $display("reset mid-sweep: %0d writes after release", n);

    // Steady state: push and pop every cycle at occupancy 2, pointers wrap many times.
    do_reset();
    for (int k = 0; k < 24; k++) begin
      r = ss_rec(k);
      rs_valid = (k < 22); rs_pc = r.pc; rs_target = r.tgt; rs_taken = r.tk;
      step();
      chk("ss_ready", rs_ready, 1);
      if (k >= 2) begin
        r = ss_rec(k - 2);
        chk_rec("ss_rec", r.pc, r.tgt, r.tk);
      end else begin
        chk("ss_no_write_yet", wr_en, 0);
      end
    end
    rs_valid = 1'b0;
    step();
    chk("ss_no_extra_write", wr_en, 0);

`ifdef BTB_UPD_STATS_EN
    do_reset();
    for (int i = 0; i < 3; i++) begin
      r = ovf_rec(i);
      rs_valid = 1'b1; rs_pc = r.pc; rs_target = r.tgt; rs_taken = r.tk;
      step();
    end
    rs_valid = 1'b0;
    repeat (8) step();
    flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    repeat (50) step();
    chk("stat_updates", stat_updates, 3);
    chk("stat_sweeps", stat_sweeps, 1);
    $display("stats: updates=%0d sweeps=%0d", stat_updates, stat_sweeps);
`endif

    do_reset();
    q.delete();
    sweep_next = 5'd0;
    last_idx = 5'd0; last_tag = 25'd0; last_tgt = 32'd0; last_tk = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      r.pc  = $urandom;
      r.tgt = $urandom;
      r.tk  = 1'($urandom_range(0, 1));
      rs_valid  = ($urandom_range(0, 2) != 0);
      rs_pc     = r.pc;
      rs_target = r.tgt;
      rs_taken  = r.tk;
      flush_req = ($urandom_range(0, 79) == 0);
      acc = rs_valid && (q.size() < DEPTH);
      step();
      rand_observe(acc, r);
    end
    rs_valid = 1'b0;
    flush_req = 1'b0;
    for (int c = 0; c < 200; c++) begin
      step();
      rand_observe(1'b0, r);
    end
    chk("rnd_queue_drained", q.size(), 0);
    chk("rnd_sweep_complete", sweep_next, 0);
    chk("rnd_busy_end", flush_busy, 0);
    chk("rnd_wr_en_end", wr_en, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
